// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type, width constants and the BCD digit check
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DIV, DONE} state_e;
  localparam int BCD_MAX = 9;
  localparam int BIN_W = 7;
  localparam int REM_W = 4;
  function automatic logic is_bcd(input logic [3:0] n);
    return n <= 4'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_div5_seq_if.sv
// bcd_div5_seq_if: operand (in_valid/in_ready/d/u) and result (out_valid/out_ready/q/r/err) handshakes
interface bcd_div5_seq_if;
  import bcd_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [3:0] d;
  logic [3:0] u;
  logic out_valid;
  logic out_ready;
  logic [BIN_W-1:0] q;
  logic [REM_W-1:0] r;
  logic err;
  modport master (output in_valid, d, u, out_ready, input in_ready, out_valid, q, r, err);
  modport slave (input in_valid, d, u, out_ready, output in_ready, out_valid, q, r, err);
endinterface

// File: rtl/bcd2bin_2dig.sv
// bcd2bin_2dig: d,u BCD digits -> bin = d*10+u, ok = both digits are legal BCD
module bcd2bin_2dig
  import bcd_pkg::*;
(
  input  logic [3:0]       d,
  input  logic [3:0]       u,
  output logic [BIN_W-1:0] bin,
  output logic             ok
);
  always_comb begin
    ok = is_bcd(d) && is_bcd(u);
    bin = BIN_W'({3'd0, d} * 7'd10) + {3'd0, u};
  end
endmodule

// File: rtl/bcd_div5_seq.sv
// bcd_div5_seq: clk, rst_n, bus (slave) -- two-digit BCD to binary, then divide by DIVISOR via repeated subtraction
module bcd_div5_seq
  import bcd_pkg::*;
#(
  parameter int DIVISOR = 5
) (
  input logic         clk,
  input logic         rst_n,
  bcd_div5_seq_if.slave bus
);
  if (DIVISOR < 1 || DIVISOR > 9) begin : g_bad_divisor
    $error("DIVISOR must be in 1..9");
  end
  localparam logic [BIN_W-1:0] DIV_V = BIN_W'(DIVISOR);
  state_e state_q, state_d;
  logic [3:0] d_q, d_d, u_q, u_d;
  logic [BIN_W-1:0] acc_q, acc_d, cnt_q, cnt_d, q_q, q_d;
  logic [REM_W-1:0] r_q, r_d;
  logic err_q, err_d;
  logic [BIN_W-1:0] bin;
  logic ok;
  bcd2bin_2dig u_conv (.d(d_q), .u(u_q), .bin(bin), .ok(ok));
  // cnt_q is the running quotient; the visible q_q only updates on entry to DONE
  always_comb begin
    state_d = state_q;
    d_d = d_q;
    u_d = u_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    q_d = q_q;
    r_d = r_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        d_d = bus.d;
        u_d = bus.u;
        state_d = CONV;
      end
      CONV: if (!ok) begin
        err_d = 1'b1;
        q_d = '0;
        r_d = '0;
        state_d = DONE;
      end else begin
        acc_d = bin;
        cnt_d = '0;
        state_d = DIV;
      end
      DIV: if (acc_q >= DIV_V) begin
        acc_d = acc_q - DIV_V;
        cnt_d = cnt_q + 1'b1;
      end else begin
        q_d = cnt_q;
        r_d = acc_q[REM_W-1:0];
        err_d = 1'b0;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q <= '0;
      u_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      u_q <= u_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      r_q <= r_d;
      err_q <= err_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.q = q_q;
  assign bus.r = r_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_div5_seq.sv
// tb_bcd_div5_seq: directed vector table plus backpressure and reset sequences for bcd_div5_seq
module tb_bcd_div5_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int failed = 0;
  bcd_div5_seq_if bus ();
  bcd_div5_seq #(.DIVISOR(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] d;
    logic [3:0] u;
    int q;
    int r;
    int e;
    int lat;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic accept(input logic [3:0] dd, input logic [3:0] uu);
    @(negedge clk);
    bus.d = dd;
    bus.u = uu;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.d = 4'hf;
    bus.u = 4'hf;
  endtask
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after_hs", int'(bus.in_ready), 1);
    chk("out_valid_after_hs", int'(bus.out_valid), 0);
  endtask
  task automatic run_vec(input string name, input vec_t v);
    int lat;
    accept(v.d, v.u);
    wait_valid(lat);
    chk({name, "_lat"}, lat, v.lat);
    chk({name, "_q"}, int'(bus.q), v.q);
    chk({name, "_r"}, int'(bus.r), v.r);
    chk({name, "_err"}, int'(bus.err), v.e);
    handshake();
  endtask
  initial begin
    int lat;
    vec_t v;
    vecs[0] = '{d: 4, u: 5, q: 9, r: 0, e: 0, lat: 11};
    vecs[1] = '{d: 0, u: 0, q: 0, r: 0, e: 0, lat: 2};
    vecs[2] = '{d: 9, u: 9, q: 19, r: 4, e: 0, lat: 21};
    vecs[3] = '{d: 1, u: 10, q: 0, r: 0, e: 1, lat: 1};
    vecs[4] = '{d: 12, u: 0, q: 0, r: 0, e: 1, lat: 1};
    vecs[5] = '{d: 0, u: 5, q: 1, r: 0, e: 0, lat: 3};
    vecs[6] = '{d: 0, u: 4, q: 0, r: 4, e: 0, lat: 2};
    vecs[7] = '{d: 6, u: 7, q: 13, r: 2, e: 0, lat: 15};
    bus.in_valid = 1'b0;
    bus.d = '0;
    bus.u = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_q", int'(bus.q), 0);
    chk("rst_r", int'(bus.r), 0);
    chk("rst_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    // multiply-by-5 outputs for i=0..9 must divide back to i
    for (int i = 0; i < 10; i++) begin
      v = '{d: 4'((5 * i) / 10), u: 4'((5 * i) % 10), q: i, r: 0, e: 0, lat: i + 2};
      run_vec($sformatf("rt%0d", i), v);
    end
    // backpressure, early out_ready, busy in_valid pulses
    accept(4'd3, 4'd7);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.out_ready = 1'b1;
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.d = 4'd0;
        bus.u = 4'd0;
      end
      if (i == 4) begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
      end
      if (i < 4) chk($sformatf("bp_busy_in_ready%0d", i), int'(bus.in_ready), 0);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    chk("bp_lat", lat, 9);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_valid%0d", k), int'(bus.out_valid), 1);
      chk($sformatf("bp_hold_q%0d", k), int'(bus.q), 7);
      chk($sformatf("bp_hold_r%0d", k), int'(bus.r), 2);
      @(posedge clk);
      #1;
    end
    handshake();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_latched_op", int'(bus.in_ready), 1);
    chk("bp_q_kept", int'(bus.q), 7);
    // reset while DONE drops out_valid without a clock edge
    accept(4'd2, 4'd0);
    wait_valid(lat);
    chk("rd_lat", lat, 6);
    rst_n = 1'b0;
    #1;
    chk("rd_out_valid", int'(bus.out_valid), 0);
    chk("rd_in_ready", int'(bus.in_ready), 1);
    chk("rd_q", int'(bus.q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // reset during DIV discards the pending result
    accept(4'd8, 4'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rdiv_out_valid", int'(bus.out_valid), 0);
    chk("rdiv_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rdiv_discarded", int'(bus.out_valid), 0);
    v = '{d: 2, u: 5, q: 5, r: 0, e: 0, lat: 7};
    run_vec("after_rst", v);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bcd_div5_seq.md
Name: bcd_div5_seq

Overview:
- Sequential inverse of the combinational multiply-by-5 BCD block in Laborator 3.
- Accepts a two-digit BCD value (tens d, units u) and converts it to binary.
- Divides the binary value by DIVISOR (default 5) by repeated subtraction and returns quotient and remainder.
- Uses valid/ready handshakes on both input and output sides.
- Used to recover the original operand i from the multiplier's d/u outputs, and as a lab exercise in FSM-driven arithmetic.

Parameters:
- DIVISOR, 5, constant divisor; legal range 1..9; elaboration error outside this range.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  d/u present and valid.
- in_ready  output  1  block can accept an operand.
- d  input  4  BCD tens digit.
- u  input  4  BCD units digit.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- q  output  7  quotient.
- r  output  4  remainder.
- err  output  1  input contained a non-BCD digit (>9).

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n). All state is cleared immediately on assertion.
- Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, r=0, err=0, internal acc=0, captured digits=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid && in_ready, capture d,u, then go to CONV. in_ready=0 in every other state.
  - CONV: if either captured digit >9, go to DONE with err=1, q=0, r=0. Otherwise load acc = d*10+u (7 bits, max 99), clear q, go to DIV.
  - DIV: each cycle, if acc >= DIVISOR then acc -= DIVISOR and q += 1. Otherwise set r = acc[3:0], err=0, go to DONE.
  - DONE: out_valid=1. q, r and err are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- Latency and throughput:
  - out_valid rises q+2 cycles after the accepting edge for valid input.
  - out_valid rises 1 cycle after the accepting edge for invalid input.
  - No back-to-back accept: in_ready returns 1 in the cycle after the result handshake.
- Outputs are registered. q, r and err change only on the transition into DONE or on reset. q/r/err are not cleared on leaving DONE.
- Boundaries:
  - Value 0: immediate DIV exit, q=0, r=0.
  - Value 99, DIVISOR=1: q=99, which fits in 7 bits.
  - acc == DIVISOR: one subtraction, then exit with r=0.
  - in_valid while busy: ignored; the input is not latched.
  - d/u changing after accept: no effect on the result.
  - out_ready high before out_valid: no effect.
  - Reset asserted mid-CONV/DIV/DONE: return to IDLE, pending result discarded, out_valid drops asynchronously.
- Remainder is always < DIVISOR. Invariant: q*DIVISOR + r == 10*d+u when err=0.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, CONV, DIV, DONE}.
  - constants BCD_MAX=9, BIN_W=7, REM_W=4.
  - helper function is_bcd(nibble).
- One natural sub-module, bcd2bin_2dig: combinational (d*10+u) with a digit-valid flag, instantiated inside CONV.

Test Plan:
- d=4,u=5 (45), DIVISOR=5 -> q=9, r=0, err=0; out_valid 11 cycles after accept.
- d=0,u=0 -> q=0, r=0; out_valid 2 cycles after accept. d=9,u=9 -> q=19, r=4; latency 21.
- d=1,u=10 (invalid units) -> err=1, q=0, r=0; out_valid 1 cycle after accept. d=12,u=0 gives the same response.
- Round trip: for i=0..9, drive d/u with the multiply-by-5 BCD outputs -> q=i, r=0 for every i.
- Backpressure: d=3,u=7, out_ready held low 5 cycles after out_valid -> q=7, r=2 stable throughout; in_valid pulses while busy are ignored; in_ready=1 the cycle after handshake.
- Reset: rst_n low for 1 cycle while in DIV (d=8,u=0) -> out_valid=0 and in_ready=1 immediately. A new operand d=2,u=5 afterwards -> q=5, r=0.
